// File: rtl/led_scanner.sv
// LED scanner output stage: moves a head across NLEDS LEDs (bounce or
// wrap), leaves a decaying brightness tail, and renders each LED's
// brightness with a shared free-running PWM counter.
module led_scanner #(
  parameter int NLEDS       = 8,
  parameter int PWM_BITS    = 8,
  parameter int DECAY_SHIFT = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_step,
  input  logic                     i_enable,
  input  logic                     i_mode,
  output logic [NLEDS-1:0]         o_leds,
  output logic [$clog2(NLEDS)-1:0] o_pos,
  output logic                     o_dir
);

  localparam int POS_W = $clog2(NLEDS);

  localparam logic [PWM_BITS-1:0] MAX         = '1;
  localparam logic [POS_W-1:0]    LAST_POS    = POS_W'(NLEDS - 1);
  localparam logic [POS_W-1:0]    BEFORE_LAST = POS_W'(NLEDS - 2);
  localparam logic [POS_W-1:0]    POS_ONE     = POS_W'(1);

  localparam logic MODE_BOUNCE = 1'b0;
  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;

  logic [POS_W-1:0]    pos;
  logic                dir;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] bright [NLEDS];

  logic [POS_W-1:0]    next_pos;
  logic                next_dir;
  logic [NLEDS-1:0]    led_cmp;

  // Head movement for the next accepted step, selected by the pattern mode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // so no path through the if/else can leave it unassigned and infer a latch.
    next_pos = pos;
    next_dir = dir;
    if (i_mode == MODE_BOUNCE) begin
      if (dir == DIR_UP) begin
        if (pos == LAST_POS) begin
          next_pos = BEFORE_LAST;
          next_dir = DIR_DOWN;
        end else begin
          next_pos = pos + POS_ONE;
        end
      end else begin
        if (pos == '0) begin
          next_pos = POS_ONE;
          next_dir = DIR_UP;
        end else begin
          next_pos = pos - POS_ONE;
        end
      end
    end else begin
      // Wrap always rotates upward, whatever direction bounce left behind.
      next_dir = DIR_UP;
      next_pos = (pos == LAST_POS) ? '0 : pos + POS_ONE;
    end
  end

  // Per-LED unsigned PWM compare against the shared counter.
  always_comb begin
    led_cmp = '0;
    for (int k = 0; k < NLEDS; k++) begin
      led_cmp[k] = (bright[k] > pwm_cnt);
    end
  end

  // Scanner state, PWM counter and registered LED drive.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    if (i_reset) begin
      pos     <= '0;
      dir     <= DIR_UP;
      pwm_cnt <= '0;
      o_leds  <= '0;
      // NOTE: the brightness array is a handful of flops, not a RAM, and the
      // head must be lit right after reset, so every entry is reset.
      for (int k = 0; k < NLEDS; k++) begin
        bright[k] <= (k == 0) ? MAX : '0;
      end
    end else if (i_enable) begin
      pwm_cnt <= pwm_cnt + 1'b1;
      o_leds  <= led_cmp;
      if (i_step) begin
        pos <= next_pos;
        dir <= next_dir;
        // Decay the whole tail; the new head position overrides its decay.
        for (int k = 0; k < NLEDS; k++) begin
          bright[k] <= (POS_W'(k) == next_pos) ? MAX : (bright[k] >> DECAY_SHIFT);
        end
      end
    end else begin
      // Frozen: state holds, LEDs blank.
      o_leds <= '0;
    end
  end

  assign o_pos = pos;
  assign o_dir = dir;

endmodule

// File: tb/tb_led_scanner.sv
// Directed testbench for led_scanner with default parameters (8 LEDs,
// 8-bit PWM, decay shift 1). Brightness is observed as high counts over
// full 256-cycle PWM windows.
module tb_led_scanner;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_step;
  logic       i_enable;
  logic       i_mode;
  logic [7:0] o_leds;
  logic [2:0] o_pos;
  logic       o_dir;

  int checks   = 0;
  int failures = 0;
  int cnt [8];

  always #5 i_clk = ~i_clk;

  led_scanner dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_step   (i_step),
    .i_enable (i_enable),
    .i_mode   (i_mode),
    .o_leds   (o_leds),
    .o_pos    (o_pos),
    .o_dir    (o_dir)
  );

  // Advance one clock and settle just after the edge.
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Two reset cycles with a step and enable asserted, then idle enabled in bounce.
  task automatic apply_reset;
    i_reset  = 1'b1;
    i_step   = 1'b1;
    i_enable = 1'b1;
    i_mode   = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
    i_step  = 1'b0;
  endtask

  // n back-to-back accepted steps.
  task automatic steps(input int n);
    i_step = 1'b1;
    repeat (n) tick();
    i_step = 1'b0;
  endtask

  // High counts per LED over one full PWM period.
  task automatic measure;
    for (int k = 0; k < 8; k++) cnt[k] = 0;
    repeat (256) begin
      tick();
      for (int k = 0; k < 8; k++) if (o_leds[k]) cnt[k]++;
    end
  endtask

  task automatic check_window(input string name, input int exp_cnt [8]);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cnt[k] !== exp_cnt[k]) begin
        failures++;
        $display("FAIL %s led%0d high_count got=%0d expected=%0d", name, k, cnt[k], exp_cnt[k]);
      end
    end
  endtask

  task automatic check_pos_dir(input string name, input logic [2:0] ep, input logic ed);
    checks++;
    if (o_pos !== ep || o_dir !== ed) begin
      failures++;
      $display("FAIL %s pos/dir got=%0d/%0d expected=%0d/%0d", name, o_pos, o_dir, ep, ed);
    end
  endtask

  task automatic test_reset;
    int exp_cnt [8] = '{255, 0, 0, 0, 0, 0, 0, 0};
    apply_reset();
    checks++;
    if (o_leds !== 8'h00) begin
      failures++;
      $display("FAIL reset_leds got=%h expected=00", o_leds);
    end
    check_pos_dir("reset", 3'd0, 1'b0);
    measure();
    check_window("reset_pwm", exp_cnt);
  endtask

  task automatic test_bounce;
    apply_reset();
    i_step = 1'b1;
    for (int s = 1; s <= 15; s++) begin
      tick();
      if (s == 7)  check_pos_dir("bounce_s7", 3'd7, 1'b0);
      if (s == 8)  check_pos_dir("bounce_s8", 3'd6, 1'b1);
      if (s == 14) check_pos_dir("bounce_s14", 3'd0, 1'b1);
      if (s == 15) check_pos_dir("bounce_s15", 3'd1, 1'b0);
    end
    i_step = 1'b0;
  endtask

  task automatic test_decay;
    int exp_cnt [8] = '{31, 63, 127, 255, 0, 0, 0, 0};
    apply_reset();
    steps(3);
    check_pos_dir("decay_pos", 3'd3, 1'b0);
    measure();
    check_window("decay", exp_cnt);
  endtask

  task automatic test_wrap;
    apply_reset();
    i_mode = 1'b1;
    i_step = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      tick();
      check_pos_dir($sformatf("wrap_s%0d", s), 3'(s % 8), 1'b0);
    end
    i_step = 1'b0;
    i_mode = 1'b0;
  endtask

  task automatic test_mode_switch;
    apply_reset();
    steps(9);
    check_pos_dir("switch_pre", 3'd5, 1'b1);
    i_mode = 1'b1;
    steps(1);
    check_pos_dir("switch_post", 3'd6, 1'b0);
    i_mode = 1'b0;
  endtask

  task automatic test_disable;
    int bad = 0;
    apply_reset();
    steps(2);          // bright = 63,127,255; pwm_cnt = 2
    repeat (98) tick(); // pwm_cnt = 100
    i_enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      i_step = (i % 10 == 0);
      tick();
      if (o_leds !== 8'h00) bad++;
    end
    i_step = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL disable_blank nonzero_cycles got=%0d expected=0", bad);
    end
    check_pos_dir("disable_hold", 3'd2, 1'b0);
    i_enable = 1'b1;
    tick();
    // Resumes from held pwm_cnt = 100: only 127 and 255 exceed it.
    checks++;
    if (o_leds !== 8'b0000_0110) begin
      failures++;
      $display("FAIL disable_resume_pwm got=%b expected=00000110", o_leds);
    end
    steps(1);
    check_pos_dir("disable_first_step", 3'd3, 1'b0);
  endtask

  task automatic test_reset_mid_scan;
    int exp_cnt [8] = '{255, 0, 0, 0, 0, 0, 0, 0};
    apply_reset();
    steps(10);
    check_pos_dir("midscan_pre", 3'd4, 1'b1);
    i_reset = 1'b1;
    i_step  = 1'b1;
    tick();
    check_pos_dir("midscan_reset", 3'd0, 1'b0);
    checks++;
    if (o_leds !== 8'h00) begin
      failures++;
      $display("FAIL midscan_leds got=%h expected=00", o_leds);
    end
    i_reset = 1'b0;
    i_step  = 1'b0;
    measure();
    check_window("midscan_pwm", exp_cnt);
  endtask

  initial begin
    i_reset  = 1'b1;
    i_step   = 1'b0;
    i_enable = 1'b0;
    i_mode   = 1'b0;
    test_reset();
    test_bounce();
    test_decay();
    test_wrap();
    test_mode_switch();
    test_disable();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_scanner.md
# led_scanner

Downstream LED output stage for the MAX1000 board: it takes a slow single-cycle step strobe, such as the rollover of the free-running blink counter, and drives all eight user LEDs with a bouncing or rotating "scanner" pattern. Each position advance leaves a fading tail. Per-LED brightness is rendered by a shared free-running PWM counter. The block replaces the static "LEDs off" drive on the unused LEDs with a complete 8-LED output.

## Interface

Parameters:
- NLEDS, default 8: number of LEDs driven. Must be ≥ 2.
- PWM_BITS, default 8: width of the brightness values and of the PWM counter. Must be ≥ 2.
- DECAY_SHIFT, default 1: right-shift applied to every brightness value on each step. Legal range is 1..PWM_BITS.

Ports:
- i_clk, input, 1: the 12 MHz board clock. This is the only clock.
- i_reset, input, 1: reset, synchronous and active-high.
- i_step, input, 1: single-cycle advance strobe. Back-to-back pulses are legal.
- i_enable, input, 1: when 1, the block runs. When 0, the block freezes and blanks.
- i_mode, input, 1: selects the pattern. 0 = bounce (ping-pong), 1 = wrap (rotate up).
- o_leds, output, NLEDS: PWM LED drive, active-high, registered.
- o_pos, output, $clog2(NLEDS): current head position.
- o_dir, output, 1: current head direction. 0 = up, 1 = down.

## Operation

State:
- pos
- dir
- pwm_cnt, PWM_BITS wide
- bright[k] for each LED, PWM_BITS wide, unsigned
- MAX = 2^PWM_BITS − 1

Reset (highest priority; overrides i_step, i_enable and i_mode in the same cycle):
- pos = 0, dir = 0
- bright[0] = MAX, all other bright[k] = 0
- pwm_cnt = 0
- o_leds = 0

PWM:
- While i_enable = 1, pwm_cnt increments every cycle and wraps from MAX to 0.
- o_leds[k] is registered as (bright[k] > pwm_cnt). Comparison is unsigned.
- bright = MAX gives MAX/256 duty. bright = 0 gives a constant 0.

A step is accepted when i_step = 1 and i_enable = 1. On an accepted step, all of the following happen in one cycle:
- Every bright[k] becomes bright[k] >> DECAY_SHIFT.
- pos and dir are updated according to the mode (below).
- bright[new pos] is then overwritten with MAX. The head write wins over the decay.

Bounce mode (i_mode = 0):
- dir = 0 and pos < NLEDS−1: pos + 1.
- dir = 0 and pos = NLEDS−1: pos = NLEDS−2, dir = 1.
- dir = 1 and pos > 0: pos − 1.
- dir = 1 and pos = 0: pos = 1, dir = 0.

Wrap mode (i_mode = 1):
- pos = (pos + 1) mod NLEDS.
- dir is forced to 0.
- The mode is sampled only on accepted steps. Switching to wrap while dir = 1 clears dir and increments pos on the next step.

Disable (i_enable = 0):
- pwm_cnt, pos, dir and bright hold their values.
- Steps are ignored.
- o_leds is driven to 0 on the next clock.
- On re-enable, PWM resumes from the held pwm_cnt.

o_pos and o_dir are direct register outputs of pos and dir.

## Timing

- Step latency: i_step high in cycle n → pos, dir and bright are updated at the edge ending cycle n. o_pos and o_dir show the new values in cycle n+1.
- Output latency: o_leds uses the updated brightness from cycle n+2, because of the registered compare.
- PWM period: 2^PWM_BITS cycles, i.e. 256 cycles = 21.33 µs (46.9 kHz) at 12 MHz.
- Disable latency: i_enable falling in cycle n → o_leds = 0 from cycle n+1.
- Reset latency: i_reset high in cycle n → all outputs at their reset values in cycle n+1.
- Step rate: one step per cycle is supported with no lost steps.

## Test plan

1. Reset: hold i_reset for 2 cycles with i_step = 1.
   - Required: o_leds = 0, o_pos = 0, o_dir = 0.
   - Then release reset with i_enable = 1, i_step = 0. Over 256 cycles, o_leds[0] is high for 255 cycles and o_leds[7:1] stay 0.
2. Bounce, i_mode = 0, from reset:
   - After 7 steps: o_pos = 7, o_dir = 0.
   - Step 8: o_pos = 6, o_dir = 1.
   - Step 14: o_pos = 0.
   - Step 15: o_pos = 1, o_dir = 0.
3. Decay, DECAY_SHIFT = 1: 3 steps from reset.
   - Required bright[0..3] = 31, 63, 127, 255; all others 0.
   - Measured high counts per 256-cycle window must match these values exactly.
4. Wrap and mode switch:
   - i_mode = 1, 8 steps from reset: o_pos goes 1, 2, …, 7, 0 with o_dir = 0 throughout.
   - Bounce until pos = 5, dir = 1, then set i_mode = 1. Next step: o_pos = 6, o_dir = 0.
5. Disable: drop i_enable for 100 cycles while pulsing i_step every 10 cycles.
   - Required: o_leds = 0 from the next cycle onward, and o_pos is unchanged.
   - Re-enable: the PWM pattern resumes and the first new step advances pos by exactly 1.
6. Reset mid-scan: at pos = 4, dir = 1, assert i_reset in the same cycle as i_step.
   - Required: o_pos = 0, o_dir = 0, bright equal to the reset pattern.
   - The step is ignored.
